// File: rtl/adsr_envelope.sv
// adsr_envelope
//   ADSR envelope generator feeding the PWM output stage. The 8-bit oscillator
//   sample is scaled by the upper byte of a 16-bit envelope level. The level
//   moves through ATTACK/DECAY/SUSTAIN/RELEASE on a divided tick, so the
//   envelope can span milliseconds at system-clock rates.
//
//   Parameters
//     TICK_DIV         clock cycles per envelope step (>=1)
//   Ports
//     clk_in           system clock
//     rst_in           synchronous, active-high reset
//     gate_in          note held (1) / released (0)
//     sample_in        unsigned oscillator sample
//     attack_rate_in   level increment per tick in ATTACK (0 = instant)
//     decay_rate_in    level decrement per tick in DECAY (0 = instant)
//     sustain_in       sustain level, upper byte of the 16-bit level
//     release_rate_in  level decrement per tick in RELEASE (0 = instant)
//     dc_out           (sample * env) >> 8, to the PWM duty-cycle input
//     env_out          level[15:8]
//     active_out       envelope not idle, drives the PWM gate
module adsr_envelope #(
  parameter int TICK_DIV = 1024
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        gate_in,
  input  logic [7:0]  sample_in,
  input  logic [15:0] attack_rate_in,
  input  logic [15:0] decay_rate_in,
  input  logic [7:0]  sustain_in,
  input  logic [15:0] release_rate_in,
  output logic [7:0]  dc_out,
  output logic [7:0]  env_out,
  output logic        active_out
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ATTACK  = 3'd1;
  localparam logic [2:0] ST_DECAY   = 3'd2;
  localparam logic [2:0] ST_SUSTAIN = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  logic [DIV_W-1:0] div_q;
  logic             tick;
  logic             gate_q;
  logic             rise, fall;
  logic [2:0]       state_q, state_d;
  logic [15:0]      level_q, level_d;

  // Free-running step divider; gate edges never restart it.
  assign tick = (div_q == DIV_LAST);

  always_ff @(posedge clk_in) begin
    if (rst_in)    div_q <= '0;
    else if (tick) div_q <= '0;
    else           div_q <= div_q + 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) gate_q <= 1'b0;
    else        gate_q <= gate_in;
  end

  assign rise = gate_in & ~gate_q;
  assign fall = ~gate_in & gate_q;

  // Step arithmetic, evaluated every cycle and used only on a tick.
  logic [16:0] atk_sum;
  logic [15:0] sus_lvl;
  logic [15:0] dec_diff;
  logic        atk_done, dec_done, rel_done;

  assign sus_lvl  = {sustain_in, 8'h00};
  assign atk_sum  = {1'b0, level_q} + {1'b0, attack_rate_in};
  assign atk_done = (attack_rate_in == 16'd0) | atk_sum[16] |
                    (atk_sum[15:0] == 16'hFFFF);
  assign dec_diff = level_q - decay_rate_in;
  // A borrow counts as reaching the target.
  assign dec_done = (decay_rate_in == 16'd0) | (level_q < decay_rate_in) |
                    (dec_diff <= sus_lvl);
  assign rel_done = (release_rate_in == 16'd0) | (level_q <= release_rate_in);

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    if (rise) begin
      // Retrigger from wherever the level is; no step this cycle.
      state_d = ST_ATTACK;
    end else if (fall) begin
      if (state_q == ST_ATTACK || state_q == ST_DECAY || state_q == ST_SUSTAIN)
        state_d = ST_RELEASE;
    end else begin
      case (state_q)
        ST_IDLE: level_d = 16'd0;
        ST_ATTACK: if (tick) begin
          if (atk_done) begin
            level_d = 16'hFFFF;
            state_d = ST_DECAY;
          end else begin
            level_d = atk_sum[15:0];
          end
        end
        ST_DECAY: if (tick) begin
          if (dec_done) begin
            level_d = sus_lvl;
            state_d = ST_SUSTAIN;
          end else begin
            level_d = dec_diff;
          end
        end
        // Tracks sustain_in live, independent of the tick.
        ST_SUSTAIN: level_d = sus_lvl;
        ST_RELEASE: if (tick) begin
          if (rel_done) begin
            level_d = 16'd0;
            state_d = ST_IDLE;
          end else begin
            level_d = level_q - release_rate_in;
          end
        end
        default: begin
          level_d = 16'd0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      level_q <= 16'd0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
    end
  end

  // Output stage: registered copies of level/state, and a one-cycle scaled
  // sample. 0xFF * 0xFF >> 8 = 0xFE, so full scale tops out at 0xFE.
  logic [15:0] prod;
  assign prod = {8'h00, sample_in} * {8'h00, env_out};

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      env_out    <= 8'h00;
      active_out <= 1'b0;
      dc_out     <= 8'h00;
    end else begin
      env_out    <= level_q[15:8];
      active_out <= (state_q != ST_IDLE);
      dc_out     <= prod[15:8];
    end
  end

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope with TICK_DIV=4. Cycle numbers count
// rising edges since the most recent reset release; ticks land on edges
// 4, 8, 12, ... Level changes appear on env_out one edge later.
module tb_adsr_envelope;
  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        gate_in;
  logic [7:0]  sample_in;
  logic [15:0] attack_rate_in, decay_rate_in, release_rate_in;
  logic [7:0]  sustain_in;
  logic [7:0]  dc_out, env_out;
  logic        active_out;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  adsr_envelope #(.TICK_DIV(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .gate_in(gate_in),
    .sample_in(sample_in), .attack_rate_in(attack_rate_in),
    .decay_rate_in(decay_rate_in), .sustain_in(sustain_in),
    .release_rate_in(release_rate_in), .dc_out(dc_out),
    .env_out(env_out), .active_out(active_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic adv_to(input int n);
    while (cyc < n) begin
      @(posedge clk_in);
      cyc++;
    end
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_in = 1'b1; gate_in = 1'b0; sample_in = 8'hFF;
    attack_rate_in = 16'h4000; decay_rate_in = 16'h1000;
    sustain_in = 8'h80; release_rate_in = 16'h2000;
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_env", env_out, 8'h00);
    chk("rst_dc", dc_out, 8'h00);
    chk("rst_active", {7'b0, active_out}, 8'h00);

    // Note on: rise at edge 2, attack ticks at 4/8/12/16.
    rst_in = 1'b0; cyc = 0;
    adv_to(1);   gate_in = 1'b1;
    adv_to(3);   chk("atk_active", {7'b0, active_out}, 8'h01);
    adv_to(5);   chk("atk_t1", env_out, 8'h40);
    adv_to(8);   chk("atk_hold", env_out, 8'h40);
    adv_to(9);   chk("atk_t2", env_out, 8'h80);
    adv_to(13);  chk("atk_t3", env_out, 8'hC0);
    adv_to(17);  chk("atk_peak", env_out, 8'hFF);
    adv_to(18);  chk("dc_full", dc_out, 8'hFE);
    adv_to(45);  chk("dec_t7", env_out, 8'h8F);
    adv_to(49);  chk("sus_env", env_out, 8'h80);
    adv_to(50);  chk("sus_dc", dc_out, 8'h7F);

    // Release from 0x8000 at 0x2000/tick: fall at 51, ticks 52..64.
    gate_in = 1'b0;
    adv_to(53);  chk("rel_t1", env_out, 8'h60);
    adv_to(64);  chk("rel_active_last", {7'b0, active_out}, 8'h01);
    adv_to(65);  chk("rel_idle_active", {7'b0, active_out}, 8'h00);
    chk("rel_idle_env", env_out, 8'h00);

    // Fresh note (rise 66) to SUSTAIN at 112, fall at 114, 0x6000 at 116,
    // retrigger rise at 117.
    gate_in = 1'b1;
    adv_to(113); chk("note2_sus", env_out, 8'h80);
    gate_in = 1'b0;
    adv_to(116); gate_in = 1'b1;
    adv_to(118); chk("retrig_hold", env_out, 8'h60);
    chk("retrig_active", {7'b0, active_out}, 8'h01);
    adv_to(121); chk("retrig_step", env_out, 8'hA0);

    // Carry at 128 -> DECAY, SUSTAIN again at 160; then live sustain change.
    adv_to(161); chk("note2_sus2", env_out, 8'h80);
    sustain_in = 8'h20;
    adv_to(163); chk("sus_track", env_out, 8'h20);
    adv_to(164); chk("sus_track_dc", dc_out, 8'h1F);

    // Release at 0x0800: fall 165, 0x1800 at tick 168; rise lands on tick 172.
    gate_in = 1'b0; release_rate_in = 16'h0800;
    adv_to(171); gate_in = 1'b1;
    adv_to(173); chk("edge_over_tick", env_out, 8'h18);
    adv_to(177); chk("post_edge_step", env_out, 8'h58);

    // Reset mid-note, gate still held.
    rst_in = 1'b1;
    adv_to(178); chk("rst2_env", env_out, 8'h00);
    chk("rst2_active", {7'b0, active_out}, 8'h00);
    chk("rst2_dc", dc_out, 8'h00);

    // Gate high at reset release is a rise; reset again at level 0xC000.
    rst_in = 1'b0; cyc = 0;
    adv_to(2);   chk("gate_held_rise", {7'b0, active_out}, 8'h01);
    adv_to(13);  chk("atk_c000", env_out, 8'hC0);
    rst_in = 1'b1;
    adv_to(14);  chk("rst3_env", env_out, 8'h00);
    chk("rst3_active", {7'b0, active_out}, 8'h00);
    chk("rst3_dc", dc_out, 8'h00);

    // All rates zero, sustain 0x40: rise at 2, ticks 4/8, fall 10, tick 12.
    rst_in = 1'b0; gate_in = 1'b0; cyc = 0;
    attack_rate_in = 16'h0; decay_rate_in = 16'h0; release_rate_in = 16'h0;
    sustain_in = 8'h40;
    adv_to(1);   gate_in = 1'b1;
    adv_to(5);   chk("z_atk", env_out, 8'hFF);
    adv_to(6);   chk("z_atk_dc", dc_out, 8'hFE);
    adv_to(7);   chk("z_dec_wait", env_out, 8'hFF);
    adv_to(9);   chk("z_sus", env_out, 8'h40);
    gate_in = 1'b0;
    adv_to(10);  chk("z_sus_dc", dc_out, 8'h3F);
    adv_to(11);  chk("z_rel_wait", env_out, 8'h40);
    adv_to(12);  chk("z_rel_active", {7'b0, active_out}, 8'h01);
    adv_to(13);  chk("z_idle_env", env_out, 8'h00);
    chk("z_idle_active", {7'b0, active_out}, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/adsr_envelope.md
Name: adsr_envelope

Overview:
- ADSR envelope generator that drives the synth's PWM output stage.
- Takes an 8-bit unsigned oscillator sample and a note gate. Shapes the sample's amplitude with attack/decay/sustain/release.
- Outputs an 8-bit duty-cycle value and an active flag, which connect directly to the PWM stage's duty-cycle and gate inputs.
- Envelope level advances on a divided tick, so ms-scale envelopes are reachable from the system clock.

Parameters:
- TICK_DIV, 1024: clock cycles per envelope step (>=1); tick pulse when divider == TICK_DIV-1.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous, active-high reset
- gate_in  input  1  note held (1) / released (0)
- sample_in  input  8  unsigned oscillator sample
- attack_rate_in  input  16  level increment per tick in ATTACK; 0 = instant
- decay_rate_in  input  16  level decrement per tick in DECAY; 0 = instant
- sustain_in  input  8  sustain level (upper byte of 16-bit level)
- release_rate_in  input  16  level decrement per tick in RELEASE; 0 = instant
- dc_out  output  8  scaled sample to the PWM duty-cycle input
- env_out  output  8  current envelope level, level[15:8]
- active_out  output  1  high whenever state != IDLE; drives the PWM gate

Behaviour:
- Clock and reset: one clock, clk_in. Reset is synchronous and active-high on rst_in.
- Reset: state=IDLE, level=0, tick divider=0, gate_q=0, dc_out=0, env_out=0, active_out=0. A reset mid-note aborts immediately, with no release.
- Gate edge detection: gate_q is a registered copy of gate_in. rise = gate_in & ~gate_q; fall = ~gate_in & gate_q.
- States and actions: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE. The level register is 16 bits unsigned.
  - Any state, on rise: next state ATTACK. Level is kept, not zeroed (retrigger from the current level).
  - ATTACK, on fall: next state RELEASE.
  - DECAY, on fall: next state RELEASE.
  - SUSTAIN, on fall: next state RELEASE.
- Edge priority: an edge transition takes priority over a tick in the same cycle. No level step occurs in that cycle.
- Level steps happen only on a tick cycle with no edge:
  - ATTACK: level += attack_rate, computed 17-bit. On carry or a result of 0xFFFF, level=0xFFFF and go to DECAY. If rate is 0, level=0xFFFF and go to DECAY.
  - DECAY: target = {sustain_in, 8'h00}. If level - decay_rate <= target (or underflows), level=target and go to SUSTAIN. Otherwise subtract. If rate is 0, jump to target.
  - SUSTAIN: level = {sustain_in, 8'h00} every cycle, tracking live changes to sustain_in. No tick needed.
  - RELEASE: if level <= release_rate, level=0 and go to IDLE. Otherwise subtract. If rate is 0, level=0 and go to IDLE.
  - IDLE: level stays 0.
- Tick divider free-runs from reset and is not restarted by gate edges.
- Outputs (all registered):
  - env_out = level[15:8].
  - active_out = (state != IDLE).
  - dc_out(n+1) = (sample_in(n) * env_out(n)) >> 8, using the full 16-bit product and taking the upper byte. One-cycle latency.
  - env=0xFF with sample=0xFF gives 0xFE. Full scale reaches 0xFE, never 0xFF. This is accepted.
- A gate pulse shorter than one cycle between samples is not detected.
- A gate held high at reset release is seen as a rise on the first cycle after reset, because gate_q=0.

Test Plan:
- TICK_DIV=4, attack 0x4000, decay 0x1000, sustain 0x80, release 0x2000; gate rises, sample 0xFF.
  - Level goes 0x4000, 0x8000, 0xC000, 0xFFFF (4 ticks, then DECAY).
  - 8 ticks later level=0x8000 (SUSTAIN), env_out=0x80, dc_out=0x7F.
- Gate falls from SUSTAIN 0x8000 with release 0x2000 -> 4 ticks to level 0, IDLE, active_out=0 the cycle after the final tick.
- Gate rises during RELEASE at level 0x6000 with attack 0x4000 -> ATTACK from 0x6000; next tick 0xA000; no drop to 0.
- All rates 0, sustain 0x40 -> rise: first tick 0xFFFF, second tick 0x4000 SUSTAIN. Fall: first tick 0, IDLE.
- In SUSTAIN, change sustain_in 0x80 -> 0x20 -> env_out=0x20 within 2 cycles, no tick required. A rise coincident with a tick produces no level step that cycle.
- Assert rst_in mid-ATTACK (level 0xC000) -> next cycle all outputs 0, state IDLE. Gate still high after reset release -> treated as a rise, ATTACK starts.
